y86_pipe_reg: RTL and testbench
===============================

# y86_pipe_reg

Parametrised elastic pipeline-stage register for the Y86 pipeline. It carries a stage's status code, instruction code and a width-configurable payload to the next stage. It supports hazard-unit stall and bubble injection, and it adds a valid/ready handshake with an optional second (skid) entry. It replaces the per-stage hand-written F/D/E/M/W registers and adds saturating stall/bubble performance counters.

## Interface
Parameters:
- PAYLOAD_W, default 136: payload width (e.g. valE + valM + dstE + dstM for the W stage).
- DEPTH, default 2: buffer entries; legal values 1 (plain register) or 2 (main + skid).
- CNT_W, default 16: width of each performance counter.
- NOP_ICODE, default 4'h1: icode loaded on bubble and at reset.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: upstream entry present.
- in_ready, out, 1: block accepts an entry this cycle.
- in_stat, in, 2: upstream status.
- in_icode, in, 4: upstream icode.
- in_payload, in, PAYLOAD_W: upstream payload.
- stall, in, 1: hazard-unit stall; freezes the block.
- bubble, in, 1: hazard-unit bubble; flush and inject NOP.
- out_valid, out, 1: main entry valid.
- out_ready, in, 1: downstream accepts.
- out_stat, out, 2: status of the main entry.
- out_icode, out, 4: icode of the main entry.
- out_payload, out, PAYLOAD_W: payload of the main entry.
- occupancy, out, 2: entries held (0..DEPTH).
- stall_cnt, out, CNT_W: cycles with stall=1, saturating.
- bubble_cnt, out, CNT_W: accepted bubbles, saturating.
- err, out, 1: sticky; set when stall and bubble are both high in one cycle.

## Operation
- Storage: main entry (drives the out_* ports) and, when DEPTH=2, a skid entry. Both entries are registers.
- Definitions: push = in_valid & in_ready. pop = out_valid & out_ready & !stall.
- Priority per cycle: stall > bubble > handshake.
- stall=1:
  - No push and no pop.
  - All entries and outputs hold.
  - in_ready=0.
  - stall_cnt increments.
- bubble=1 with stall=0:
  - Both entries are discarded.
  - Main loads stat=STAT_AOK, icode=NOP_ICODE, payload=0.
  - occupancy becomes 1 and out_valid becomes 1.
  - in_ready=0 and pop is ignored.
  - bubble_cnt increments.
- Both stall and bubble high: the stall behaviour applies, and err sets. err clears only on reset.
- in_ready = !stall & !bubble & (occupancy < DEPTH). in_ready has no combinational path from out_ready.
- Handshake moves (no stall, no bubble):
  - occupancy 0, push: data goes to main.
  - occupancy 1, push and pop: data goes to main.
  - occupancy 1, push without pop: data goes to skid (DEPTH=2 only).
  - occupancy 1, pop without push: main empties.
  - occupancy 2, pop: skid moves to main and the skid entry empties.
- in_stat passes through unmodified. The block never alters a non-AOK status.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous assert, synchronous deassert at the next edge):
  - occupancy=0, out_valid=0.
  - out_stat=STAT_AOK, out_icode=NOP_ICODE, out_payload=0.
  - stall_cnt=0, bubble_cnt=0, err=0.
  - in_ready follows its equation after reset, so it is 1 when stall=0 and bubble=0.
- Latency: push in cycle N puts the data on out_* in cycle N+1 when the buffer was empty, or when occupancy was 1 and a pop occurred in cycle N.
- Throughput: one entry per cycle while out_ready=1.
- Bubble visibility: bubble in cycle N puts the NOP on the outputs in cycle N+1.
- Reset during any operation: all entries are lost immediately, with no further pop.
- DEPTH=1: in_ready = !stall & !bubble & (!out_valid | out_ready). This is the only combinational ready path and is allowed only for DEPTH=1.

## Structure
- Shared package y86_pkg contains:
  - stat codes: STAT_AOK=2'd0, STAT_HLT=2'd1, STAT_ADR=2'd2, STAT_INS=2'd3;
  - icode constants, including I_NOP=4'h1.
- One sub-module, y86_sat_counter (CNT_W, inc, clk, rst_n, count), instantiated twice for the two counters.
- Per-stage wrappers (F/D/E/M/W) pack their own fields into in_payload. Payload field layouts live in y86_pkg.

## Test plan
- Reset check: reset, release; push stat=0, icode=4'h6, payload=0x1234.
  - During reset: out_valid=0, out_icode=4'h1.
  - Next cycle: out_icode=4'h6, out_payload=0x1234, occupancy=1.
- Skid fill: out_ready=0, push A then B.
  - occupancy=2 and in_ready=0.
  - Raise out_ready: A then B appear on consecutive cycles.
- Stall hold: with A in main, hold stall=1 for 5 cycles while in_valid=1 and out_ready=1.
  - Outputs stay A, in_ready=0, stall_cnt=5.
- Bubble flush: occupancy=2, then bubble=1.
  - Next cycle: occupancy=1, out_icode=4'h1, out_payload=0, bubble_cnt=1.
- Conflict: assert stall=1 and bubble=1 together.
  - State holds and err=1.
  - err stays 1 through later traffic until rst_n is asserted.
- Saturation with CNT_W=4: hold stall=1 for 20 cycles.
  - stall_cnt=15 and stays 15.

Source files
------------

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86 status codes, icodes and stage payload layouts
// Purpose: common constants for the Y86 pipeline registers and their stage wrappers.
// Ports: none (package).
package y86_pkg;

  // Status codes carried alongside every pipeline entry.
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Instruction codes.
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // W-stage payload layout: {valE, valM, dstE, dstM}, LSB offsets.
  localparam int W_DSTM_LSB  = 0;
  localparam int W_DSTE_LSB  = 4;
  localparam int W_VALM_LSB  = 8;
  localparam int W_VALE_LSB  = 72;
  localparam int W_PAYLOAD_W = 136;

  // M-stage payload layout: {valE, valA, dstE, dstM}, LSB offsets.
  localparam int M_DSTM_LSB  = 0;
  localparam int M_DSTE_LSB  = 4;
  localparam int M_VALA_LSB  = 8;
  localparam int M_VALE_LSB  = 72;
  localparam int M_PAYLOAD_W = 136;

endpackage

// File: rtl/y86_sat_counter.sv
// rtl/y86_sat_counter.sv - saturating event counter
// Purpose: counts cycles with inc=1, sticking at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), inc (count enable), count (current value).
module y86_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/y86_pipe_reg.sv
// rtl/y86_pipe_reg.sv - elastic Y86 pipeline-stage register with stall/bubble
// Purpose: one pipeline stage register (main + optional skid entry) with valid/ready
//   handshake, hazard stall/bubble control, saturating perf counters and a sticky
//   stall+bubble conflict flag.
// Ports: clk, rst_n; upstream in_valid/in_ready/in_stat/in_icode/in_payload;
//   hazard stall, bubble; downstream out_valid/out_ready/out_stat/out_icode/out_payload;
//   status occupancy, stall_cnt, bubble_cnt, err.
module y86_pipe_reg
  import y86_pkg::*;
#(
  parameter int         PAYLOAD_W = 136,
  parameter int         DEPTH     = 2,
  parameter int         CNT_W     = 16,
  parameter logic [3:0] NOP_ICODE = 4'h1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_stat,
  input  logic [3:0]           in_icode,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 stall,
  input  logic                 bubble,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_stat,
  output logic [3:0]           out_icode,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic                 err
);

  logic [1:0]           main_stat_q,  main_stat_d;
  logic [3:0]           main_icode_q, main_icode_d;
  logic [PAYLOAD_W-1:0] main_pl_q,    main_pl_d;
  logic [1:0]           skid_stat_q,  skid_stat_d;
  logic [3:0]           skid_icode_q, skid_icode_d;
  logic [PAYLOAD_W-1:0] skid_pl_q,    skid_pl_d;
  logic [1:0]           occ_q,        occ_d;
  logic                 err_q,        err_d;
  logic                 push, pop;

  assign out_valid = (occ_q != 2'd0);

  // Only the single-entry variant looks at out_ready; the skid entry exists so
  // that DEPTH=2 can keep in_ready purely registered.
  always_comb begin
    in_ready = 1'b0;
    if (DEPTH == 1) begin
      in_ready = !stall && !bubble && (!out_valid || out_ready);
    end else begin
      in_ready = !stall && !bubble && (occ_q < 2'(DEPTH));
    end
  end

  assign push = in_valid && in_ready;
  // A bubble flushes everything, so a concurrent downstream accept is ignored.
  assign pop  = out_valid && out_ready && !stall && !bubble;

  always_comb begin
    main_stat_d  = main_stat_q;
    main_icode_d = main_icode_q;
    main_pl_d    = main_pl_q;
    skid_stat_d  = skid_stat_q;
    skid_icode_d = skid_icode_q;
    skid_pl_d    = skid_pl_q;
    occ_d        = occ_q;
    err_d        = err_q || (stall && bubble);

    if (stall) begin
      // hold everything
    end else if (bubble) begin
      main_stat_d  = STAT_AOK;
      main_icode_d = NOP_ICODE;
      main_pl_d    = '0;
      occ_d        = 2'd1;
    end else begin
      unique case (occ_q)
        2'd0: begin
          if (push) begin
            main_stat_d  = in_stat;
            main_icode_d = in_icode;
            main_pl_d    = in_payload;
            occ_d        = 2'd1;
          end
        end
        2'd1: begin
          if (push) begin
            if (pop) begin
              main_stat_d  = in_stat;
              main_icode_d = in_icode;
              main_pl_d    = in_payload;
            end else begin
              skid_stat_d  = in_stat;
              skid_icode_d = in_icode;
              skid_pl_d    = in_payload;
              occ_d        = 2'd2;
            end
          end else if (pop) begin
            occ_d = 2'd0;
          end
        end
        default: begin
          // Full: in_ready is low, so only a pop can happen.
          if (pop) begin
            main_stat_d  = skid_stat_q;
            main_icode_d = skid_icode_q;
            main_pl_d    = skid_pl_q;
            occ_d        = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_stat_q  <= STAT_AOK;
      main_icode_q <= NOP_ICODE;
      main_pl_q    <= '0;
      skid_stat_q  <= STAT_AOK;
      skid_icode_q <= NOP_ICODE;
      skid_pl_q    <= '0;
      occ_q        <= 2'd0;
      err_q        <= 1'b0;
    end else begin
      main_stat_q  <= main_stat_d;
      main_icode_q <= main_icode_d;
      main_pl_q    <= main_pl_d;
      skid_stat_q  <= skid_stat_d;
      skid_icode_q <= skid_icode_d;
      skid_pl_q    <= skid_pl_d;
      occ_q        <= occ_d;
      err_q        <= err_d;
    end
  end

  assign out_stat    = main_stat_q;
  assign out_icode   = main_icode_q;
  assign out_payload = main_pl_q;
  assign occupancy   = occ_q;
  assign err         = err_q;

  y86_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (stall_cnt)
  );

  // Only bubbles that take effect are counted; a stall overrides the bubble.
  y86_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble && !stall),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_y86_pipe_reg.sv
// tb/tb_y86_pipe_reg.sv - self-checking bench for y86_pipe_reg (DEPTH=2 and DEPTH=1)
module tb_y86_pipe_reg;
  import y86_pkg::*;

  localparam int PW = 16;
  localparam int CW = 4;
  localparam int CMAX = 15;

  typedef struct packed {
    logic [1:0]    s;
    logic [3:0]    i;
    logic [PW-1:0] p;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, stall, bubble, out_ready;
  logic [1:0]    in_stat;
  logic [3:0]    in_icode;
  logic [PW-1:0] in_payload;

  logic          rdy_w   [2];
  logic          ovld_w  [2];
  logic [1:0]    ostat_w [2];
  logic [3:0]    oic_w   [2];
  logic [PW-1:0] opl_w   [2];
  logic [1:0]    occ_w   [2];
  logic [CW-1:0] scnt_w  [2];
  logic [CW-1:0] bcnt_w  [2];
  logic          err_w   [2];

  y86_pipe_reg #(.PAYLOAD_W(PW), .DEPTH(2), .CNT_W(CW), .NOP_ICODE(4'h1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[0]),
    .in_stat(in_stat), .in_icode(in_icode), .in_payload(in_payload),
    .stall(stall), .bubble(bubble), .out_valid(ovld_w[0]), .out_ready(out_ready),
    .out_stat(ostat_w[0]), .out_icode(oic_w[0]), .out_payload(opl_w[0]),
    .occupancy(occ_w[0]), .stall_cnt(scnt_w[0]), .bubble_cnt(bcnt_w[0]), .err(err_w[0])
  );

  y86_pipe_reg #(.PAYLOAD_W(PW), .DEPTH(1), .CNT_W(CW), .NOP_ICODE(4'h1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[1]),
    .in_stat(in_stat), .in_icode(in_icode), .in_payload(in_payload),
    .stall(stall), .bubble(bubble), .out_valid(ovld_w[1]), .out_ready(out_ready),
    .out_stat(ostat_w[1]), .out_icode(oic_w[1]), .out_payload(opl_w[1]),
    .occupancy(occ_w[1]), .stall_cnt(scnt_w[1]), .bubble_cnt(bcnt_w[1]), .err(err_w[1])
  );

  // Reference model: each instance is a FIFO of up to depth entries, head shown on out_*.
  ent_t mbuf [2][2];
  int   mcnt [2];
  int   msc  [2];
  int   mbc  [2];
  bit   merr [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; msc[k] = 0; mbc[k] = 0; merr[k] = 1'b0;
    end
  endtask

  task automatic chk_state();
    for (int k = 0; k < 2; k++) begin
      int d;
      d = depth_of(k);
      chk($sformatf("D%0d out_valid", d), ovld_w[k], (mcnt[k] > 0));
      chk($sformatf("D%0d occupancy", d), occ_w[k], mcnt[k]);
      if (mcnt[k] > 0) begin
        chk($sformatf("D%0d out_stat", d), ostat_w[k], mbuf[k][0].s);
        chk($sformatf("D%0d out_icode", d), oic_w[k], mbuf[k][0].i);
        chk($sformatf("D%0d out_payload", d), opl_w[k], mbuf[k][0].p);
      end
      chk($sformatf("D%0d stall_cnt", d), scnt_w[k], msc[k]);
      chk($sformatf("D%0d bubble_cnt", d), bcnt_w[k], mbc[k]);
      chk($sformatf("D%0d err", d), err_w[k], merr[k]);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs checked.
  task automatic cycle(input bit v, input logic [1:0] s, input logic [3:0] ic,
                       input logic [PW-1:0] p, input bit st, input bit bu, input bit ordy);
    in_valid = v; in_stat = s; in_icode = ic; in_payload = p;
    stall = st; bubble = bu; out_ready = ordy;
    #1;
    for (int k = 0; k < 2; k++) begin
      int  d, cnt;
      bit  rdy, pop, push;
      d   = depth_of(k);
      cnt = mcnt[k];
      rdy = !st && !bu && ((d == 2) ? (cnt < 2) : (cnt == 0 || ordy));
      chk($sformatf("D%0d in_ready", d), rdy_w[k], rdy);
      if (st) begin
        if (msc[k] < CMAX) msc[k]++;
        if (bu) merr[k] = 1'b1;
      end else if (bu) begin
        mbuf[k][0] = {STAT_AOK, I_NOP, PW'(0)};
        mcnt[k] = 1;
        if (mbc[k] < CMAX) mbc[k]++;
      end else begin
        pop  = (cnt > 0) && ordy;
        push = v && rdy;
        if (pop) begin
          mbuf[k][0] = mbuf[k][1];
          cnt--;
        end
        if (push) begin
          mbuf[k][cnt] = {s, ic, p};
          cnt++;
        end
        mcnt[k] = cnt;
      end
    end
    @(negedge clk);
    chk_state();
  endtask

  task automatic do_reset();
    in_valid = 0; stall = 0; bubble = 0; out_ready = 0;
    in_stat = 0; in_icode = 0; in_payload = 0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst out_valid", ovld_w[k], 1'b0);
      chk("rst out_icode", oic_w[k], 4'h1);
      chk("rst out_stat", ostat_w[k], STAT_AOK);
      chk("rst out_payload", opl_w[k], 0);
      chk("rst occupancy", occ_w[k], 0);
      chk("rst err", err_w[k], 1'b0);
      chk("rst stall_cnt", scnt_w[k], 0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [PW-1:0] PA = 16'hAAA1;
  localparam logic [PW-1:0] PB = 16'hBBB2;

  initial begin
    rst_n = 1'b0;
    in_valid = 0; stall = 0; bubble = 0; out_ready = 0;
    in_stat = 0; in_icode = 0; in_payload = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset then first push.
    cycle(1, STAT_AOK, 4'h6, 16'h1234, 0, 0, 0);
    chk("first icode", oic_w[0], 4'h6);
    chk("first payload", opl_w[0], 16'h1234);
    chk("first occupancy", occ_w[0], 2'd1);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // Skid fill then drain.
    cycle(1, STAT_HLT, I_IRMOVQ, PA, 0, 0, 0);
    cycle(1, STAT_ADR, I_RMMOVQ, PB, 0, 0, 0);
    chk("skid occupancy", occ_w[0], 2'd2);
    chk("skid in_ready", rdy_w[0], 1'b0);
    chk("skid head A", opl_w[0], PA);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk("drain B", opl_w[0], PB);
    chk("drain B stat", ostat_w[0], STAT_ADR);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // Stall hold for 5 cycles with A in main.
    cycle(1, STAT_AOK, I_OPQ, PA, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, STAT_INS, I_RET, PB, 1, 0, 1);
    chk("stall hold A", opl_w[0], PA);
    chk("stall_cnt 5", scnt_w[0], 4'd5);

    // Bubble flush from full.
    cycle(1, STAT_AOK, I_CALL, PB, 0, 0, 0);
    cycle(1, STAT_AOK, I_JXX, PA, 0, 0, 0);
    cycle(1, STAT_AOK, I_JXX, PA, 0, 1, 1);
    chk("bubble occupancy", occ_w[0], 2'd1);
    chk("bubble icode", oic_w[0], 4'h1);
    chk("bubble payload", opl_w[0], 0);
    chk("bubble_cnt 1", bcnt_w[0], 4'd1);

    // Conflict: err sticks through traffic until reset.
    cycle(1, STAT_AOK, I_POPQ, PA, 1, 1, 1);
    chk("conflict err", err_w[0], 1'b1);
    for (int i = 0; i < 6; i++)
      cycle($urandom_range(0, 1), 2'($urandom), 4'($urandom), PW'($urandom), 0, 0,
            $urandom_range(0, 1));
    chk("err sticky", err_w[0], 1'b1);
    do_reset();

    // Randomized traffic, occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, 2'($urandom), 4'($urandom), PW'($urandom),
              $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 2) != 0);
      end
    end

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 1, 0, 1);
    chk("stall_cnt sat", scnt_w[0], 4'd15);
    cycle(0, 0, 0, 0, 1, 0, 1);
    chk("stall_cnt sat hold", scnt_w[0], 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
